freq_report_ctrl: RTL and testbench

- Sequences the UART byte transmitter that reports each frequency measurement as one fixed-length ASCII frame.
- Latches a 27-bit binary measurement and converts it to 8 BCD digits with a sequential double-dabble.
- Drives the transmitter's rising-edge-triggered enable and byte input, one byte per fixed time slot. The transmitter has no ready signal, so pacing is by time slot only.
- Frame is 12 bytes: 8 digits, 'H', 'z', CR, LF.

---
 rtl/freq_report_ctrl.sv | 146 ++++++++++++++
 tb/tb_freq_report_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_report_ctrl.sv
// Frequency report sequencer: latches a 27-bit measurement and converts it to BCD
// by double-dabble, then paces a 12-byte "DDDDDDDDHz\r\n" frame into a UART
// transmitter, one byte per slot. Optional macro LEAD_ZERO_BLANK_EN blanks leading zeros.
module freq_report_ctrl #(
    parameter int CLK_FREQ  = 50000000,
    parameter int UART_BPS  = 9600,
    parameter int GUARD_CYC = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        meas_valid,
    input  logic [26:0] meas_data,
    output logic        uart_en,
    output logic [7:0]  uart_din,
    output logic        busy,
    output logic        meas_drop
);
    localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int SLOT_CYC = BPS_CNT * 10 + GUARD_CYC;
    localparam int EN_HIGH  = 4;
    localparam int SLOT_W   = $clog2(SLOT_CYC);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0] EN_OFF    = SLOT_W'(EN_HIGH);
    localparam logic [26:0]       MAX_VAL   = 27'd99999999;

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t             state_reg, state_next;
    logic [26:0]        shift_reg;
    logic [31:0]        bcd_reg;
    logic [31:0]        bcd_adj;
    logic [4:0]         conv_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [3:0]         byte_idx;
    logic [3:0]         digit      [8];
    logic [7:0]         digit_char [8];
    logic [7:0]         byte_sel;
    logic               last_cycle;

    // Nibble corrections for the double-dabble step and the ASCII digit map (MSD at index 0).
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_nib
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
            assign digit[gi] = bcd_reg[31-gi*4 -: 4];
`ifdef LEAD_ZERO_BLANK_EN
            if (gi < 7) begin : g_blank
                logic lead_zero;
                if (gi == 0) begin : g_first
                    assign lead_zero = (digit[gi] == 4'd0);
                end else begin : g_rest
                    assign lead_zero = g_nib[gi-1].g_blank.lead_zero && (digit[gi] == 4'd0);
                end
                assign digit_char[gi] = lead_zero ? 8'h20 : {4'h3, digit[gi]};
            end else begin : g_last
                assign digit_char[gi] = {4'h3, digit[gi]};
            end
`else
            assign digit_char[gi] = {4'h3, digit[gi]};
`endif
        end
    endgenerate

    always_comb begin
        byte_sel = 8'h00;
        case (byte_idx)
            4'd8:    byte_sel = 8'h48;
            4'd9:    byte_sel = 8'h7A;
            4'd10:   byte_sel = 8'h0D;
            4'd11:   byte_sel = 8'h0A;
            default: if (byte_idx < 4'd8) byte_sel = digit_char[byte_idx[2:0]];
        endcase
    end

    assign last_cycle = (slot_cnt == SLOT_LAST) && (byte_idx == 4'd11);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (meas_valid) state_next = CONV;
            CONV:    if (conv_cnt == 5'd26) state_next = SEND;
            SEND:    if (last_cycle) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_reg <= IDLE;
        else            state_reg <= state_next;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            conv_cnt  <= '0;
            slot_cnt  <= '0;
            byte_idx  <= '0;
            uart_en   <= 1'b0;
            uart_din  <= 8'h00;
            busy      <= 1'b0;
            meas_drop <= 1'b0;
        end else begin
            // Any valid outside IDLE (including the final slot cycle) is discarded.
            meas_drop <= meas_valid && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (meas_valid) begin
                        shift_reg <= (meas_data > MAX_VAL) ? MAX_VAL : meas_data;
                        bcd_reg   <= '0;
                        conv_cnt  <= '0;
                        slot_cnt  <= '0;
                        byte_idx  <= '0;
                        busy      <= 1'b1;
                    end
                end
                CONV: begin
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    conv_cnt <= conv_cnt + 5'd1;
                end
                SEND: begin
                    if (slot_cnt == '0) begin
                        uart_din <= byte_sel;
                        uart_en  <= 1'b1;
                    end else if (slot_cnt == EN_OFF) begin
                        uart_en  <= 1'b0;
                    end
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (byte_idx == 4'd11) begin
                            uart_din <= 8'h00;
                            busy     <= 1'b0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_freq_report_ctrl.sv
// Directed bench for freq_report_ctrl with a shortened slot (BPS_CNT=10, SLOT_CYC=116)
// and a behavioural UART transmitter/receiver loop on uart_en/uart_din.
module tb_freq_report_ctrl;
    localparam int BPS  = 10;
    localparam int SLOT = BPS * 10 + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        meas_valid = 1'b0;
    logic [26:0] meas_data = '0;
    logic        uart_en;
    logic [7:0]  uart_din;
    logic        busy;
    logic        meas_drop;

    freq_report_ctrl #(.CLK_FREQ(1000), .UART_BPS(100), .GUARD_CYC(16)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .meas_valid(meas_valid), .meas_data(meas_data),
        .uart_en(uart_en), .uart_din(uart_din), .busy(busy), .meas_drop(meas_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Byte/edge monitor, sampled 1 time unit after each rising edge.
    logic [7:0] byte_q[$];
    int         rise_q[$];
    int         drop_cnt = 0;
    int         din_chg = 0;
    logic       en_prev = 1'b0;
    logic [7:0] din_prev = 8'h00;
    always @(posedge clk) begin
        #1;
        if (uart_en && !en_prev) begin
            byte_q.push_back(uart_din);
            rise_q.push_back(cyc);
        end else if (busy && uart_din !== din_prev) begin
            din_chg++;
        end
        if (meas_drop) drop_cnt++;
        en_prev  = uart_en;
        din_prev = uart_din;
    end

    // Transmitter model (2-stage edge detect, 8N1) and receiver decoding its line.
    logic [2:0] en_s = '0;
    int         tx_cnt, tx_bit, rx_cnt;
    logic [9:0] tx_sh;
    bit         tx_busy = 0, rx_busy = 0;
    logic       line = 1'b1;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    int         ovl = 0, ferr = 0;
    always @(negedge clk) begin
        en_s = {en_s[1:0], uart_en};
        if (!rst_n) begin
            tx_busy = 0; rx_busy = 0; line = 1'b1;
        end else begin
            if (tx_busy) begin
                tx_cnt++;
                if (tx_cnt == BPS) begin
                    tx_cnt = 0; tx_bit++;
                    if (tx_bit == 10) begin tx_busy = 0; line = 1'b1; end
                    else line = tx_sh[tx_bit];
                end
            end
            if (en_s[1] && !en_s[2]) begin
                if (tx_busy) ovl++;
                else begin
                    tx_sh = {1'b1, uart_din, 1'b0};
                    tx_busy = 1; tx_cnt = 0; tx_bit = 0; line = 1'b0;
                end
            end
            if (!rx_busy) begin
                if (!line) begin rx_busy = 1; rx_cnt = 0; end
            end else begin
                rx_cnt++;
                if (rx_cnt % BPS == BPS / 2) begin
                    if (rx_cnt / BPS == 0) begin
                        if (line) ferr++;
                    end else if (rx_cnt / BPS < 9) begin
                        rx_byte[rx_cnt/BPS-1] = line;
                    end else begin
                        if (!line) ferr++;
                        rx_q.push_back(rx_byte);
                        rx_busy = 0;
                    end
                end
            end
        end
    end

    task automatic clear_mon();
        byte_q.delete(); rise_q.delete(); drop_cnt = 0; din_chg = 0;
    endtask

    task automatic send_valid(input logic [26:0] v, output int t0);
        @(negedge clk);
        meas_data = v; meas_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc; meas_valid = 1'b0;
        $display("txn: meas_valid value=%0d at cycle %0d", v, t0);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(posedge clk); #1;
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (uart_en !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", uart_en); end
        n_cmp++; if (uart_din !== 8'h00) begin n_err++; $display("FAIL reset_din: got %h want 00", uart_din); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (meas_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", meas_drop); end
        @(negedge clk); rst_n = 1'b1;
        $display("txn: reset released");
    endtask

    task automatic test_frame();
        logic [95:0] exp;
        logic [7:0]  got;
        int t0;
        bit ok;
        exp = {"12345678Hz", 8'h0D, 8'h0A};
        clear_mon();
        send_valid(27'd12345678, t0);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL frame_busy_rise: got %b want 1", busy); end
        wait_cyc(t0 + 31);
        n_cmp++; if (uart_en !== 1'b1) begin n_err++; $display("FAIL frame_en_high4: got %b want 1", uart_en); end
        wait_cyc(t0 + 32);
        n_cmp++; if (uart_en !== 1'b0) begin n_err++; $display("FAIL frame_en_low5: got %b want 0", uart_en); end
        wait_idle(13 * SLOT, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL frame_timeout: busy still %b want 0", busy); end
        n_cmp++; if (cyc !== t0 + 27 + 12 * SLOT) begin n_err++; $display("FAIL frame_busy_fall: got %0d want %0d", cyc - t0, 27 + 12 * SLOT); end
        n_cmp++; if (uart_din !== 8'h00) begin n_err++; $display("FAIL frame_din_end: got %h want 00", uart_din); end
        n_cmp++; if (byte_q.size() !== 12) begin n_err++; $display("FAIL frame_count: got %0d want 12", byte_q.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL frame_byte%0d: got %h want %h", i, got, exp[(11-i)*8 +: 8]); end
        end
        n_cmp++; if (rise_q.size() < 1 || rise_q[0] - t0 !== 28) begin n_err++; $display("FAIL frame_latency: got %0d want 28", rise_q.size() ? rise_q[0] - t0 : -1); end
        for (int i = 1; i < rise_q.size(); i++) begin
            n_cmp++; if (rise_q[i] - rise_q[i-1] !== SLOT) begin n_err++; $display("FAIL frame_spacing%0d: got %0d want %0d", i, rise_q[i] - rise_q[i-1], SLOT); end
        end
        n_cmp++; if (din_chg !== 0) begin n_err++; $display("FAIL frame_din_stable: got %0d changes want 0", din_chg); end
    endtask

    task automatic test_clamp();
        logic [26:0] vals [2];
        logic [95:0] exp;
        logic [7:0]  got;
        int t0;
        bit ok;
        vals[0] = 27'd120000000;
        vals[1] = 27'd134217727;
        exp = {"99999999Hz", 8'h0D, 8'h0A};
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_valid(vals[k], t0);
            wait_idle(13 * SLOT, ok);
            n_cmp++; if (!ok || byte_q.size() !== 12) begin n_err++; $display("FAIL clamp%0d_count: got %0d want 12", k, byte_q.size()); end
            for (int i = 0; i < 12; i++) begin
                got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
                n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL clamp%0d_byte%0d: got %h want %h", k, i, got, exp[(11-i)*8 +: 8]); end
            end
        end
    endtask

    task automatic test_zero_blank();
        logic [26:0] vals [2];
        logic [95:0] exps [2];
        logic [7:0]  got;
        int t0;
        bit ok;
        vals[0] = 27'd0;
        vals[1] = 27'd1005;
`ifdef LEAD_ZERO_BLANK_EN
        exps[0] = {"       0Hz", 8'h0D, 8'h0A};
        exps[1] = {"    1005Hz", 8'h0D, 8'h0A};
`else
        exps[0] = {"00000000Hz", 8'h0D, 8'h0A};
        exps[1] = {"00001005Hz", 8'h0D, 8'h0A};
`endif
        for (int k = 0; k < 2; k++) begin
            clear_mon();
            send_valid(vals[k], t0);
            wait_idle(13 * SLOT, ok);
            n_cmp++; if (!ok || byte_q.size() !== 12) begin n_err++; $display("FAIL zero%0d_count: got %0d want 12", k, byte_q.size()); end
            for (int i = 0; i < 12; i++) begin
                got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
                n_cmp++; if (got !== exps[k][(11-i)*8 +: 8]) begin n_err++; $display("FAIL zero%0d_byte%0d: got %h want %h", k, i, got, exps[k][(11-i)*8 +: 8]); end
            end
        end
    endtask

    task automatic test_drop();
        logic [95:0] exp;
        logic [7:0]  got;
        int t0, t1;
        bit ok;
        exp = {"12345678Hz", 8'h0D, 8'h0A};
        clear_mon();
        send_valid(27'd12345678, t0);
        wait_cyc(t0 + 28 + 3 * SLOT + 10);
        send_valid(27'd42, t1);
        n_cmp++; if (meas_drop !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b want 1", meas_drop); end
        @(posedge clk); #1;
        n_cmp++; if (meas_drop !== 1'b0) begin n_err++; $display("FAIL drop_width: got %b want 0", meas_drop); end
        wait_idle(13 * SLOT, ok);
        n_cmp++; if (!ok || byte_q.size() !== 12) begin n_err++; $display("FAIL drop_count: got %0d want 12", byte_q.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL drop_byte%0d: got %h want %h", i, got, exp[(11-i)*8 +: 8]); end
        end
        n_cmp++; if (drop_cnt !== 1) begin n_err++; $display("FAIL drop_once: got %0d want 1", drop_cnt); end
        repeat (2 * SLOT) @(posedge clk);
        #1;
        n_cmp++; if (byte_q.size() !== 12 || busy !== 1'b0) begin n_err++; $display("FAIL drop_no_second: got %0d bytes busy=%b want 12/0", byte_q.size(), busy); end
    endtask

    task automatic test_back_to_back();
        logic [95:0] exp;
        logic [7:0]  got;
        int t0, t1, last;
        bit ok;
        exp = {"00000042Hz", 8'h0D, 8'h0A};
        clear_mon();
        send_valid(27'd7, t0);
        last = t0 + 27 + 12 * SLOT;
        wait_cyc(last - 1);
        meas_data = 27'd42; meas_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || meas_drop !== 1'b1) begin n_err++; $display("FAIL b2b_same_cycle: got busy=%b drop=%b want 0/1", busy, meas_drop); end
        @(posedge clk); #1;
        t1 = cyc; meas_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || meas_drop !== 1'b0) begin n_err++; $display("FAIL b2b_next_cycle: got busy=%b drop=%b want 1/0", busy, meas_drop); end
        wait_idle(13 * SLOT, ok);
        n_cmp++; if (!ok || byte_q.size() !== 24) begin n_err++; $display("FAIL b2b_count: got %0d want 24", byte_q.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i + 12 < byte_q.size()) ? byte_q[i+12] : 8'hxx;
            n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[(11-i)*8 +: 8]); end
        end
        n_cmp++; if (rise_q.size() < 13 || rise_q[12] - t1 !== 28) begin n_err++; $display("FAIL b2b_latency: got %0d want 28", rise_q.size() > 12 ? rise_q[12] - t1 : -1); end
    endtask

    task automatic test_reset_mid();
        logic [95:0] exp;
        logic [7:0]  got;
        int t0;
        bit ok;
`ifdef LEAD_ZERO_BLANK_EN
        exp = {"       7Hz", 8'h0D, 8'h0A};
`else
        exp = {"00000007Hz", 8'h0D, 8'h0A};
`endif
        clear_mon();
        send_valid(27'd12345678, t0);
        wait_cyc(t0 + 28 + 5 * SLOT + 2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (uart_en !== 1'b0 || uart_din !== 8'h00 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_outputs: got en=%b din=%h busy=%b want 0/00/0", uart_en, uart_din, busy); end
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        $display("txn: reset released after mid-frame abort");
        clear_mon();
        send_valid(27'd7, t0);
        wait_idle(13 * SLOT, ok);
        n_cmp++; if (!ok || byte_q.size() !== 12) begin n_err++; $display("FAIL rst_mid_count: got %0d want 12", byte_q.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL rst_mid_byte%0d: got %h want %h", i, got, exp[(11-i)*8 +: 8]); end
        end
        n_cmp++; if (rise_q.size() < 1 || rise_q[0] - t0 !== 28) begin n_err++; $display("FAIL rst_mid_latency: got %0d want 28", rise_q.size() ? rise_q[0] - t0 : -1); end
    endtask

    task automatic test_loopback();
        logic [95:0] exp;
        logic [7:0]  got;
        int t0;
        bit ok;
        exp = {"12345678Hz", 8'h0D, 8'h0A};
        clear_mon();
        rx_q.delete(); ovl = 0; ferr = 0;
        send_valid(27'd12345678, t0);
        wait_idle(13 * SLOT, ok);
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() !== 12) begin n_err++; $display("FAIL loop_count: got %0d want 12", rx_q.size()); end
        for (int i = 0; i < 12; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (got !== exp[(11-i)*8 +: 8]) begin n_err++; $display("FAIL loop_byte%0d: got %h want %h", i, got, exp[(11-i)*8 +: 8]); end
        end
        n_cmp++; if (ovl !== 0 || ferr !== 0) begin n_err++; $display("FAIL loop_errors: got overlap=%0d framing=%0d want 0/0", ovl, ferr); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_clamp();
        test_zero_blank();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
